// File: rtl/sysarr_input_skew_if.sv
// Handshake and array-facing bus of the systolic-array input skew feeder.
interface sysarr_input_skew_if #(
  parameter int N  = 4,
  parameter int DW = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [N*DW-1:0]   in_data;
  logic              in_last;
  logic              stall;
  logic [N*DW-1:0]   out_value;
  logic [N-1:0]      out_valid;
  logic              out_shift;
  logic              done;

  modport master (
    output in_valid, in_data, in_last, stall,
    input  in_ready, out_value, out_valid, out_shift, done
  );

  modport slave (
    input  in_valid, in_data, in_last, stall,
    output in_ready, out_value, out_valid, out_shift, done
  );
endinterface

// File: rtl/sysarr_input_skew.sv
// Diagonal input skew for the systolic array: lane i is delayed i+1 advances.
// Optional perf counters (beat_cnt, stall_cnt) under SYSARR_SKEW_PERF_EN.
module sysarr_input_skew #(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic clk,
  input  logic nRST,
  sysarr_input_skew_if.slave bus
`ifdef SYSARR_SKEW_PERF_EN
  ,
  output logic [31:0] beat_cnt,
  output logic [31:0] stall_cnt
`endif
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            done_nxt;
  logic            accept, adv;
  logic            shift_q, done_q;

  logic [N-1:0][DW-1:0] tail_dat;
  logic [N-1:0]         tail_vld;

  assign bus.in_ready = !bus.stall && (state != DRAIN);
  assign accept       = bus.in_valid && bus.in_ready;
  assign adv          = !bus.stall && (accept || state == DRAIN);

  // Lane i: i+1 stage chain; drain cycles push bubbles in at the head.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [i:0]         vld;
    logic [i:0][DW-1:0] dat;

    always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
        vld <= '0;
        dat <= '0;
      end else if (adv) begin
        vld[0] <= accept;
        dat[0] <= accept ? bus.in_data[i*DW +: DW] : '0;
        for (int j = 1; j <= i; j++) begin
          vld[j] <= vld[j-1];
          dat[j] <= dat[j-1];
        end
      end
    end

    assign tail_vld[i] = vld[i];
    assign tail_dat[i] = dat[i];
  end

  assign bus.out_value = tail_dat;
  assign bus.out_valid = tail_vld;
  assign bus.out_shift = shift_q;
  assign bus.done      = done_q;

  // The last vector needs N advances to leave lane N-1; its own accepting
  // beat is the first of them, so the counter is primed with N-1 there.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE, STREAM: begin
        if (accept && bus.in_last) begin
          state_nxt = DRAIN;
          cnt_nxt   = CW'(N - 1);
        end else if (accept) begin
          state_nxt = STREAM;
        end
      end
      DRAIN: begin
        if (adv) begin
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      cnt     <= '0;
      shift_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shift_q <= adv;
      done_q  <= done_nxt;
    end
  end

`ifdef SYSARR_SKEW_PERF_EN
  logic tile_start;
  assign tile_start = accept && (state == IDLE);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (tile_start)
        beat_cnt <= 32'd1;
      else if (accept && beat_cnt != '1)
        beat_cnt <= beat_cnt + 32'd1;
      if (tile_start)
        stall_cnt <= '0;
      else if (bus.stall && state != IDLE && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sysarr_input_skew.sv
// Randomized bench for sysarr_input_skew against an advance-history reference model.
module tb_sysarr_input_skew;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int W  = N * DW;

  logic clk  = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  sysarr_input_skew_if #(.N(N), .DW(DW)) bus();
`ifdef SYSARR_SKEW_PERF_EN
  logic [31:0] beat_cnt, stall_cnt;
`endif

  sysarr_input_skew #(.N(N), .DW(DW)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
`ifdef SYSARR_SKEW_PERF_EN
    ,
    .beat_cnt  (beat_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Reference: every advance injects one {valid,vector}; after A advances row i
  // shows whatever was injected at advance A-i (1-based), or zero before that.
  logic [W:0] hist[$];
  bit  m_drain, m_active, m_done, m_shift;
  int  m_rem, m_beat, m_stall;
  int  n_pass = 0, n_chk = 0;
  int  shifts = 0, dones = 0;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [W-1:0] exp_val();
    logic [W-1:0] r = '0;
    logic [W:0]   h;
    int a;
    for (int i = 0; i < N; i++) begin
      a = hist.size() - i;
      if (a >= 1) begin
        h = hist[a-1];
        r[i*DW +: DW] = h[i*DW +: DW];
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] exp_vld();
    logic [N-1:0] r = '0;
    logic [W:0]   h;
    int a;
    for (int i = 0; i < N; i++) begin
      a = hist.size() - i;
      if (a >= 1) begin
        h = hist[a-1];
        r[i] = h[W];
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic model_clear();
    hist.delete();
    m_drain = 0; m_active = 0; m_done = 0; m_shift = 0;
    m_rem = 0; m_beat = 0; m_stall = 0;
  endtask

  task automatic step(input bit v, input bit last, input bit st, input logic [W-1:0] d);
    bit acc, adv;
    @(negedge clk);
    bus.in_valid = v; bus.in_last = last; bus.stall = st; bus.in_data = d;
    #1 chk("in_ready", W'(bus.in_ready), W'(!st && !m_drain));
    @(posedge clk);
    acc = v && !st && !m_drain;
    adv = !st && (acc || m_drain);
    m_shift = adv;
    m_done  = 0;
    if (st && m_active && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (acc && !m_active) begin m_beat = 1; m_stall = 0; end
    else if (acc) m_beat++;
    if (adv) hist.push_back(acc ? {1'b1, d} : {(W+1){1'b0}});
    if (acc) begin
      m_active = 1;
      if (last) begin m_drain = 1; m_rem = N - 1; end
    end else if (adv) begin
      m_rem--;
      if (m_rem == 0) begin m_drain = 0; m_active = 0; m_done = 1; end
    end
    #1;
    chk("out_value", bus.out_value, exp_val());
    chk("out_valid", W'(bus.out_valid), W'(exp_vld()));
    chk("out_shift", W'(bus.out_shift), W'(m_shift));
    chk("done", W'(bus.done), W'(m_done));
`ifdef SYSARR_SKEW_PERF_EN
    chk("beat_cnt", W'(beat_cnt), W'(m_beat));
    chk("stall_cnt", W'(stall_cnt), W'(m_stall));
`endif
    if (bus.out_shift) shifts++;
    if (bus.done) dones++;
  endtask

  // Steps until done is seen; optionally throws random stalls/inputs at the drain.
  task automatic drain(input bit rnd, output int k);
    bit seen = 0;
    k = 0;
    while (!seen && k < 60) begin
      if (rnd) step(1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, rnd_vec());
      else     step(1'b0, 1'b0, 1'b0, '0);
      k++;
      seen = bus.done;
    end
    chk("drain_done_seen", W'(seen), W'(1));
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_value"}, bus.out_value, '0);
    chk({tag, "_valid"}, W'(bus.out_valid), '0);
    chk({tag, "_shift"}, W'(bus.out_shift), '0);
    chk({tag, "_done"},  W'(bus.done), '0);
    chk({tag, "_ready"}, W'(bus.in_ready), W'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 0; bus.in_last = 0; bus.stall = 0; bus.in_data = '0;
    nRST = 0;
    #1 zero_checks("rst_async");
    model_clear();
    @(posedge clk); @(posedge clk);
    #1 zero_checks("rst_hold");
    @(negedge clk);
    nRST = 1;
  endtask

  logic [W-1:0] vec;
  int k, len;

  initial begin
    bus.in_valid = 0; bus.in_last = 0; bus.stall = 0; bus.in_data = '0;
    model_clear();

    // Reset, then idle
    do_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0, '0);

    // Single-vector tile with fixed data
    vec = {16'h456f, 16'h487e, 16'h4491, 16'h4720};
    shifts = 0; dones = 0;
    step(1'b1, 1'b1, 1'b0, vec);
    chk("row0_first", W'(bus.out_value[15:0]), W'(16'h4720));
    drain(1'b0, k);
    chk("row3_at_shift4", W'(bus.out_value[63:48]), W'(16'h456f));
    chk("row3_valid_shift4", W'(bus.out_valid[3]), W'(1));
    step(1'b0, 1'b0, 1'b0, '0);
    chk("single_shifts", W'(shifts), W'(4));
    chk("single_dones", W'(dones), W'(1));

    // Four back-to-back beats
    shifts = 0; dones = 0;
    for (int b = 0; b < 4; b++) step(1'b1, b == 3, 1'b0, rnd_vec());
    drain(1'b0, k);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("burst4_shifts", W'(shifts), W'(7));
    chk("burst4_dones", W'(dones), W'(1));

    // Upstream bubble of 3 cycles mid-tile; in_last without in_valid is ignored
    shifts = 0; dones = 0;
    step(1'b1, 1'b0, 1'b0, rnd_vec());
    step(1'b1, 1'b0, 1'b0, rnd_vec());
    step(1'b0, 1'b1, 1'b0, rnd_vec());
    k = shifts;
    step(1'b0, 1'b1, 1'b0, rnd_vec());
    step(1'b0, 1'b0, 1'b0, rnd_vec());
    chk("bubble_no_shift", W'(shifts - k), '0);
    step(1'b1, 1'b0, 1'b0, rnd_vec());
    step(1'b1, 1'b1, 1'b0, rnd_vec());
    drain(1'b0, k);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("bubble_shifts", W'(shifts), W'(7));

    // Five stall cycles at the start of the drain delay done by five
    step(1'b1, 1'b0, 1'b0, rnd_vec());
    step(1'b1, 1'b1, 1'b0, rnd_vec());
    for (int s = 0; s < 5; s++) step(1'b1, 1'b0, 1'b1, rnd_vec());
    drain(1'b0, k);
    chk("stall_drain_len", W'(k + 5), W'(N - 1 + 5));
`ifdef SYSARR_SKEW_PERF_EN
    chk("stall_cnt_5", W'(stall_cnt), W'(5));
`endif
    step(1'b0, 1'b0, 1'b0, '0);

    // Random tiles with random bubbles and stalls
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        while ($urandom_range(0, 2) == 0)
          step(1'b0, 1'($urandom), 1'($urandom), rnd_vec());
        if (b == len - 1) begin
          k = 0;
          while (!bus.in_ready && k < 20) begin
            step(1'b0, 1'b0, 1'b0, '0);
            k++;
          end
          step(1'b1, 1'b1, 1'b0, rnd_vec());
        end else begin
          step(1'b1, 1'b0, $urandom_range(0, 3) == 0, rnd_vec());
        end
      end
      drain(1'b1, k);
    end
    step(1'b0, 1'b0, 1'b0, '0);

    // Reset pulsed mid-drain
    step(1'b1, 1'b0, 1'b0, rnd_vec());
    step(1'b1, 1'b1, 1'b0, rnd_vec());
    step(1'b0, 1'b0, 1'b0, '0);
    do_reset();
    dones = 0;
    repeat (6) step(1'b0, 1'b0, 1'b0, '0);
    chk("reset_no_done", W'(dones), '0);

    // Fresh single-vector tile after the reset
    shifts = 0; dones = 0;
    step(1'b1, 1'b1, 1'b0, vec);
    chk("post_rst_row0", W'(bus.out_value[15:0]), W'(16'h4720));
    drain(1'b0, k);
    chk("post_rst_row3", W'(bus.out_value[63:48]), W'(16'h456f));
    step(1'b0, 1'b0, 1'b0, '0);
    chk("post_rst_shifts", W'(shifts), W'(4));
    chk("post_rst_dones", W'(dones), W'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
